axil_sram_slave: RTL and testbench

- AXI4-Lite slave word memory; the DMA controller's source and destination target.
- Sits directly downstream of the DMA master's AR/R and AW/W/B channels.
- Serves reads with a programmable response latency and commits writes once both address and data have been accepted.
- Returns OKAY or SLVERR per access; the read and write paths run concurrently.

---
 rtl/axil_sram_slave_if.sv | 33 +++
 rtl/axil_sram_slave.sv | 190 +++++++++++++++++++
 tb/tb_axil_sram_slave.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_sram_slave_if.sv
// AXI4-Lite bus bundle between a master (typically the DMA controller) and the SRAM slave.
interface axil_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axil_sram_slave.sv
// AXI4-Lite word memory with independent read and write FSMs and programmable read latency.
//
// state     | meaning
// W_COLLECT | accepting AW and W in any order until both are held
// W_COMMIT  | byte-masked write of the held word, BRESP computed
// W_RESP    | BVALID held until BREADY
// R_IDLE    | ARREADY high, waiting for a read address
// R_WAIT    | counting down the remaining read latency
// R_RESP    | RVALID/RDATA/RRESP held until RREADY
module axil_sram_slave #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DEPTH        = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    axil_sram_slave_if.slave bus
);
    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    // The borrow bit of the subtraction flags addresses below BASE_ADDR.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, a} - {1'b0, BASE_ADDR};
        return (a[1:0] == 2'b00) && !diff[ADDR_WIDTH] &&
               ((diff[ADDR_WIDTH-1:0] >> 2) < ADDR_WIDTH'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] offs;
        offs = a - BASE_ADDR;
        return IDX_W'(offs >> 2);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    w_state_t              w_state;
    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [3:0]            w_strb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit_en;

    assign aw_hs     = bus.AWVALID && !aw_held && (w_state == W_COLLECT);
    assign w_hs      = bus.WVALID && !w_held && (w_state == W_COLLECT);
    assign commit_en = (w_state == W_COMMIT) && addr_ok(aw_addr_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state   <= W_COLLECT;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            case (w_state)
                W_COLLECT: begin
                    if (aw_hs) begin
                        aw_addr_q <= bus.AWADDR;
                        aw_held   <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_q <= bus.WDATA;
                        w_strb_q <= bus.WSTRB;
                        w_held   <= 1'b1;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        w_state <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    bresp_q  <= addr_ok(aw_addr_q) ? OKAY : SLVERR;
                    bvalid_q <= 1'b1;
                    w_state  <= W_RESP;
                end
                W_RESP: begin
                    if (bus.BREADY) begin
                        bvalid_q <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        w_state  <= W_COLLECT;
                    end
                end
                default: w_state <= W_COLLECT;
            endcase
        end
    end

    // Array carries no reset; commit_en is gated by the async-reset write state.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_strb_q[b]) begin
                    mem[addr_idx(aw_addr_q)][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.AWREADY = !aw_held;
    assign bus.WREADY  = !w_held;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;

    r_state_t              r_state;
    logic [3:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic                  arready_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_hs = bus.ARVALID && arready_q;

    // With a latency of one the sample is taken straight off ARADDR at the handshake.
    assign rd_addr = (r_state == R_IDLE) ? bus.ARADDR : ar_addr_q;
    assign rd_ok   = addr_ok(rd_addr);
    assign rd_word = mem[addr_idx(rd_addr)];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= R_IDLE;
            r_cnt     <= '0;
            ar_addr_q <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        ar_addr_q <= bus.ARADDR;
                        arready_q <= 1'b0;
                        r_cnt     <= 4'(READ_LATENCY - 1);
                        if (READ_LATENCY == 1) begin
                            rdata_q  <= rd_ok ? rd_word : '0;
                            rresp_q  <= rd_ok ? OKAY : SLVERR;
                            rvalid_q <= 1'b1;
                            r_state  <= R_RESP;
                        end else begin
                            r_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        rdata_q  <= rd_ok ? rd_word : '0;
                        rresp_q  <= rd_ok ? OKAY : SLVERR;
                        rvalid_q <= 1'b1;
                        r_state  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (bus.RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state   <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign bus.ARREADY = arready_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RDATA   = rdata_q;
    assign bus.RRESP   = rresp_q;
endmodule

// File: tb/tb_axil_sram_slave.sv
// Directed bench for axil_sram_slave: latency-1 and latency-4 instances behind one stimulus set.
module tb_axil_sram_slave;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    axil_sram_slave_if bus1 ();
    axil_sram_slave_if bus4 ();

    axil_sram_slave #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    axil_sram_slave #(.READ_LATENCY(4)) u_dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

    // sel picks which instance sees the VALIDs and whose outputs are observed.
    logic        sel;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    assign bus1.AWADDR  = awaddr;             assign bus4.AWADDR  = awaddr;
    assign bus1.WDATA   = wdata;              assign bus4.WDATA   = wdata;
    assign bus1.WSTRB   = wstrb;              assign bus4.WSTRB   = wstrb;
    assign bus1.ARADDR  = araddr;             assign bus4.ARADDR  = araddr;
    assign bus1.BREADY  = bready;             assign bus4.BREADY  = bready;
    assign bus1.RREADY  = rready;             assign bus4.RREADY  = rready;
    assign bus1.AWVALID = awvalid && !sel;    assign bus4.AWVALID = awvalid && sel;
    assign bus1.WVALID  = wvalid && !sel;     assign bus4.WVALID  = wvalid && sel;
    assign bus1.ARVALID = arvalid && !sel;    assign bus4.ARVALID = arvalid && sel;

    assign awready = sel ? bus4.AWREADY : bus1.AWREADY;
    assign wready  = sel ? bus4.WREADY  : bus1.WREADY;
    assign bvalid  = sel ? bus4.BVALID  : bus1.BVALID;
    assign bresp   = sel ? bus4.BRESP   : bus1.BRESP;
    assign arready = sel ? bus4.ARREADY : bus1.ARREADY;
    assign rvalid  = sel ? bus4.RVALID  : bus1.RVALID;
    assign rdata   = sel ? bus4.RDATA   : bus1.RDATA;
    assign rresp   = sel ? bus4.RRESP   : bus1.RRESP;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] ref_mem [2][64];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'd256);
    endfunction

    task automatic pop_exp(output exp_t e);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            e.tag = "none"; e.data = 'x; e.resp = 'x;
        end else begin
            e = exp_q.pop_front();
        end
    endtask

    task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int b_hold);
        int   n;
        exp_t e;
        e.tag  = {tag, "_bresp"};
        e.data = '0;
        e.resp = addr_ok(addr) ? OKAY : SLVERR;
        exp_q.push_back(e);
        if (addr_ok(addr))
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[sel][addr[7:2]][8*b +: 8] = data[8*b +: 8];
        awaddr = addr; wdata = data; wstrb = strb;
        if (w_lead > 0) begin
            wvalid = 1'b1;
            n = 0; while (!wready && n < 20) begin tick(); n++; end
            tick(); wvalid = 1'b0;
            for (int i = 0; i < w_lead; i++) begin
                check({tag, "_wready_low"}, wready, 0);
                check({tag, "_no_early_b"}, bvalid, 0);
                tick();
            end
            awvalid = 1'b1;
            n = 0; while (!awready && n < 20) begin tick(); n++; end
            tick(); awvalid = 1'b0;
        end else begin
            awvalid = 1'b1; wvalid = 1'b1;
            n = 0; while (!(awready && wready) && n < 20) begin tick(); n++; end
            tick(); awvalid = 1'b0; wvalid = 1'b0;
            check({tag, "_awready_drop"}, awready, 0);
            check({tag, "_wready_drop"}, wready, 0);
        end
        n = 0; while (!bvalid && n < 20) begin tick(); n++; end
        check({tag, "_b_latency"}, n, 1);
        for (int i = 0; i < b_hold; i++) begin
            check({tag, "_bvalid_held"}, bvalid, 1);
            check({tag, "_awready_blocked"}, awready, 0);
            tick();
        end
        bready = 1'b1;
        pop_exp(e);
        check(e.tag, bresp, e.resp);
        tick(); bready = 1'b0;
        check({tag, "_bvalid_clear"}, bvalid, 0);
        check({tag, "_awready_back"}, awready, 1);
    endtask

    task automatic axi_read(input string tag, input logic [31:0] addr, input int r_hold,
                            output logic [31:0] got);
        int   n;
        exp_t e;
        e.tag  = {tag, "_rdata"};
        e.data = addr_ok(addr) ? ref_mem[sel][addr[7:2]] : 32'd0;
        e.resp = addr_ok(addr) ? OKAY : SLVERR;
        exp_q.push_back(e);
        araddr = addr; arvalid = 1'b1;
        n = 0; while (!arready && n < 20) begin tick(); n++; end
        tick(); arvalid = 1'b0;
        n = 0; while (!rvalid && n < 40) begin tick(); n++; end
        check({tag, "_r_latency"}, n, sel ? 3 : 0);
        for (int i = 0; i < r_hold; i++) begin
            check({tag, "_rvalid_held"}, rvalid, 1);
            check({tag, "_arready_low"}, arready, 0);
            check({tag, "_rdata_stable"}, rdata, exp_q[0].data);
            check({tag, "_rresp_stable"}, rresp, exp_q[0].resp);
            tick();
        end
        rready = 1'b1;
        pop_exp(e);
        check(e.tag, rdata, e.data);
        check({tag, "_rresp"}, rresp, e.resp);
        got = rdata;
        tick(); rready = 1'b0;
        check({tag, "_rvalid_clear"}, rvalid, 0);
        check({tag, "_arready_back"}, arready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] dma_buf [4];
        exp_t        e;

        sel = 1'b0; reset_n = 1'b0;
        awaddr = '0; wdata = '0; wstrb = 4'hF; araddr = '0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b1; rready = 1'b0;
        tick(); tick();
        check("rst_arready", arready, 1);
        check("rst_awready", awready, 1);
        check("rst_wready", wready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        arvalid = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        check("idle_arready", arready, 1);
        check("idle_awready", awready, 1);
        check("idle_rvalid", rvalid, 0);
        check("idle_bvalid", bvalid, 0);

        axi_write("wr10", 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
        axi_read("rd10", 32'h10, 0, got);

        axi_write("wr20_pre", 32'h20, 32'hAAAAAAAA, 4'hF, 0, 0);
        axi_write("wr20_strb", 32'h20, 32'h11223344, 4'b0011, 3, 5);
        axi_read("rd20", 32'h20, 0, got);

        axi_write("wr00", 32'h00, 32'h5555AAAA, 4'hF, 0, 0);
        axi_write("wr100_err", 32'h100, 32'hFFFFFFFF, 4'hF, 0, 0);
        axi_read("rd00_unchanged", 32'h00, 0, got);
        axi_read("rd102_err", 32'h102, 0, got);
        axi_write("wrfc", 32'hFC, 32'h0F0F0F0F, 4'hF, 0, 0);
        axi_read("rdfc", 32'hFC, 0, got);
        axi_read("rd100_err", 32'h100, 0, got);

        // Read sample and commit land on the same edge: the old word must come back.
        axi_write("rw_pre", 32'h30, 32'h11111111, 4'hF, 0, 0);
        awaddr = 32'h30; wdata = 32'h22222222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick(); awvalid = 1'b0; wvalid = 1'b0;
        e.tag = "rw_same_cycle"; e.data = ref_mem[0][12]; e.resp = OKAY;
        exp_q.push_back(e);
        araddr = 32'h30; arvalid = 1'b1;
        tick(); arvalid = 1'b0;
        check("rw_bvalid", bvalid, 1);
        check("rw_bresp", bresp, OKAY);
        check("rw_rvalid", rvalid, 1);
        pop_exp(e);
        check(e.tag, rdata, e.data);
        bready = 1'b1; rready = 1'b1;
        tick(); bready = 1'b0; rready = 1'b0;
        ref_mem[0][12] = 32'h22222222;
        axi_read("rw_after", 32'h30, 0, got);

        sel = 1'b1;
        tick();
        axi_write("l4_wr40", 32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
        axi_read("l4_rd40", 32'h40, 3, got);
        axi_read("l4_rd_err", 32'h101, 0, got);

        sel = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) axi_write("dma_pre", 32'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            axi_read("dma_src", 32'(i * 4), 0, got);
            dma_buf[i] = got;
        end
        for (int i = 0; i < 4; i++) axi_write("dma_dst", 32'h80 + 32'(i * 4), dma_buf[i], 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            axi_read("dma_chk", 32'h80 + 32'(i * 4), 0, got);
            check("dma_dst_value", got, 32'(i + 1));
        end

        // Reset lands in the commit cycle; the write to 0x84 must be dropped.
        awaddr = 32'h84; wdata = 32'hFFFF0000; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick(); awvalid = 1'b0; wvalid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid_rst_awready", awready, 1);
        check("mid_rst_wready", wready, 1);
        check("mid_rst_arready", arready, 1);
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_bresp", bresp, 0);
        check("mid_rst_rresp", rresp, 0);
        check("mid_rst_rdata", rdata, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        axi_read("rst_lost_write", 32'h84, 0, got);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
